ram_line_cache_reader: RTL and testbench

RAM_LINE_CACHE_READER -- requirements
Module: ram_line_cache_reader

---
 rtl/ram_reader_pkg.sv | 14 +
 rtl/ram_line_store.sv | 61 ++++++
 rtl/ram_line_cache_reader.sv | 206 ++++++++++++++++++++
 tb/tb_ram_line_cache_reader.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_reader_pkg.sv
// Shared types for the line-cache reader: FSM state encoding and MIG command codes.
package ram_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_FILL,
    ST_RESP
  } state_t;

  localparam logic [2:0] CMD_READ  = 3'b001;
  localparam logic [2:0] CMD_WRITE = 3'b000;

endpackage

// File: rtl/ram_line_store.sv
// Direct-mapped line storage: per-line valid/tag plus line data written one beat at a time.
module ram_line_store #(
  parameter int LINES  = 4,
  parameter int IDX_W  = 2,
  parameter int TAG_W  = 22,
  parameter int DATA_W = 64,
  parameter int BEATS  = 2,
  parameter int BEAT_W = 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [IDX_W-1:0]          rd_idx,
  output logic                      rd_valid,
  output logic [TAG_W-1:0]          rd_tag,
  output logic [DATA_W*BEATS-1:0]   rd_line,
  input  logic                      wr_en,
  input  logic [IDX_W-1:0]          wr_idx,
  input  logic [BEAT_W-1:0]         wr_beat,
  input  logic [DATA_W-1:0]         wr_data,
  input  logic                      set_en,
  input  logic [TAG_W-1:0]          set_tag,
  input  logic                      clr_all
);

  logic [DATA_W*BEATS-1:0] data_q [LINES];
  logic [TAG_W-1:0]        tag_q  [LINES];
  logic [TAG_W-1:0]        tag_d  [LINES];
  logic [LINES-1:0]        valid_q;
  logic [LINES-1:0]        valid_d;

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    if (clr_all) begin
      valid_d = '0;
    end else if (set_en) begin
      valid_d[wr_idx] = 1'b1;
      tag_d[wr_idx]   = set_tag;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      for (int i = 0; i < LINES; i++) tag_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
    end
  end

  // Line data needs no reset: it is only observed behind a set valid bit.
  always_ff @(posedge clk) begin
    if (wr_en) data_q[wr_idx][int'(wr_beat)*DATA_W +: DATA_W] <= wr_data;
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_line  = data_q[rd_idx];

endmodule

// File: rtl/ram_line_cache_reader.sv
// Read-only direct-mapped line cache in front of a MIG read channel.
// state    | meaning
// IDLE     | ready for a request; hits answered the next cycle
// ISSUE    | read command held on the MIG until ram_rdy
// FILL     | collecting read beats into the line
// RESP     | response from the freshly filled line is on rsp_*
module ram_line_cache_reader
  import ram_reader_pkg::*;
#(
  parameter int ADDR_W = 27,
  parameter int DATA_W = 64,
  parameter int BEATS  = 2,
  parameter int WORD_W = 16,
  parameter int LINES  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  output logic [WORD_W-1:0] rsp_data,
  input  logic              flush,
  output logic [ADDR_W-1:0] ram_address,
  output logic [2:0]        ram_cmd,
  output logic              ram_en,
  input  logic              ram_rdy,
  input  logic              ram_rd_valid,
  input  logic              ram_rd_data_end,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic [15:0]       hit_cnt,
  output logic [15:0]       miss_cnt
);

  localparam int LINE_W   = DATA_W * BEATS;
  localparam int WPL      = LINE_W / WORD_W;
  localparam int WSEL_LOG = $clog2(WPL);
  localparam int WSEL_W   = (WSEL_LOG > 0) ? WSEL_LOG : 1;
  localparam int IDX_LOG  = $clog2(LINES);
  localparam int IDX_W    = (IDX_LOG > 0) ? IDX_LOG : 1;
  localparam int TAG_W    = ADDR_W - WSEL_LOG - IDX_LOG;
  localparam int BEAT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(WPL - 1);

  function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_W-1:0] a);
    return IDX_W'((a >> WSEL_LOG) & ADDR_W'(LINES - 1));
  endfunction

  function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_W-1:0] a);
    return TAG_W'(a >> (WSEL_LOG + IDX_LOG));
  endfunction

  function automatic logic [WORD_W-1:0] word_of(input logic [LINE_W-1:0] l,
                                                input logic [ADDR_W-1:0] a);
    logic [WSEL_W-1:0] w;
    w = WSEL_W'(a & ADDR_W'(WPL - 1));
    return l[int'(w)*WORD_W +: WORD_W];
  endfunction

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic                flush_pend_q, flush_pend_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [WORD_W-1:0]   rsp_data_q, rsp_data_d;
  logic                ram_en_q, ram_en_d;
  logic [2:0]          ram_cmd_q, ram_cmd_d;
  logic [ADDR_W-1:0]   ram_address_q, ram_address_d;
  logic [15:0]         hit_cnt_q, hit_cnt_d;
  logic [15:0]         miss_cnt_q, miss_cnt_d;

  logic [IDX_W-1:0]    rd_idx;
  logic                rd_valid;
  logic [TAG_W-1:0]    rd_tag;
  logic [LINE_W-1:0]   rd_line;
  logic [LINE_W-1:0]   fill_line;
  logic                wr_en, set_en, clr_all, hit;

  ram_line_store #(
    .LINES(LINES), .IDX_W(IDX_W), .TAG_W(TAG_W),
    .DATA_W(DATA_W), .BEATS(BEATS), .BEAT_W(BEAT_W)
  ) u_store (
    .clk     (clk),
    .reset_n (reset_n),
    .rd_idx  (rd_idx),
    .rd_valid(rd_valid),
    .rd_tag  (rd_tag),
    .rd_line (rd_line),
    .wr_en   (wr_en),
    .wr_idx  (idx_of(req_addr_q)),
    .wr_beat (beat_q),
    .wr_data (ram_rd_data),
    .set_en  (set_en),
    .set_tag (tag_of(req_addr_q)),
    .clr_all (clr_all)
  );

  assign rd_idx = (state_q == ST_IDLE) ? idx_of(req_addr) : idx_of(req_addr_q);
  // A same-cycle flush wins over the hit check.
  assign hit    = rd_valid && (rd_tag == tag_of(req_addr)) && !flush;

  always_comb begin
    state_d       = state_q;
    req_addr_d    = req_addr_q;
    beat_d        = beat_q;
    flush_pend_d  = flush_pend_q;
    rsp_valid_d   = 1'b0;
    rsp_data_d    = rsp_data_q;
    ram_en_d      = ram_en_q;
    ram_cmd_d     = ram_cmd_q;
    ram_address_d = ram_address_q;
    hit_cnt_d     = hit_cnt_q;
    miss_cnt_d    = miss_cnt_q;
    wr_en         = 1'b0;
    set_en        = 1'b0;
    clr_all       = 1'b0;
    fill_line     = rd_line;
    fill_line[int'(beat_q)*DATA_W +: DATA_W] = ram_rd_data;

    case (state_q)
      ST_IDLE: begin
        clr_all = flush;
        if (req_valid) begin
          req_addr_d = req_addr;
          if (hit) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = word_of(rd_line, req_addr);
            if (hit_cnt_q != 16'hFFFF) hit_cnt_d = hit_cnt_q + 16'd1;
          end else begin
            state_d       = ST_ISSUE;
            ram_en_d      = 1'b1;
            ram_cmd_d     = CMD_READ;
            ram_address_d = req_addr & LINE_MASK;
            if (miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
          end
        end
      end
      ST_ISSUE: begin
        if (flush) flush_pend_d = 1'b1;
        if (ram_rdy) begin
          ram_en_d = 1'b0;
          beat_d   = '0;
          state_d  = ST_FILL;
        end
      end
      ST_FILL: begin
        if (flush) flush_pend_d = 1'b1;
        if (ram_rd_valid) begin
          wr_en = 1'b1;
          if (ram_rd_data_end) begin
            set_en      = 1'b1;
            rsp_valid_d = 1'b1;
            rsp_data_d  = word_of(fill_line, req_addr_q);
            state_d     = ST_RESP;
          end else if (beat_q != LAST_BEAT) begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: begin
        clr_all      = flush || flush_pend_q;
        flush_pend_d = 1'b0;
        state_d      = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      req_addr_q    <= '0;
      beat_q        <= '0;
      flush_pend_q  <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      ram_en_q      <= 1'b0;
      ram_cmd_q     <= CMD_WRITE;
      ram_address_q <= '0;
      hit_cnt_q     <= '0;
      miss_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      req_addr_q    <= req_addr_d;
      beat_q        <= beat_d;
      flush_pend_q  <= flush_pend_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      ram_en_q      <= ram_en_d;
      ram_cmd_q     <= ram_cmd_d;
      ram_address_q <= ram_address_d;
      hit_cnt_q     <= hit_cnt_d;
      miss_cnt_q    <= miss_cnt_d;
    end
  end

  assign req_ready   = (state_q == ST_IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign ram_en      = ram_en_q;
  assign ram_cmd     = ram_cmd_q;
  assign ram_address = ram_address_q;
  assign hit_cnt     = hit_cnt_q;
  assign miss_cnt    = miss_cnt_q;

endmodule

// File: tb/tb_ram_line_cache_reader.sv
// Bench for ram_line_cache_reader: directed table, multi-cycle corner sequences, randomized traffic.
module tb_ram_line_cache_reader;

  localparam int ADDR_W = 27;
  localparam int DATA_W = 64;
  localparam int WORD_W = 16;
  localparam int LINES  = 4;
  localparam int BEATS  = 2;
  localparam int WPL    = 8;

  logic              clk, reset_n;
  logic              req_valid, req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              rsp_valid;
  logic [WORD_W-1:0] rsp_data;
  logic              flush;
  logic [ADDR_W-1:0] ram_address;
  logic [2:0]        ram_cmd;
  logic              ram_en, ram_rdy, ram_rd_valid, ram_rd_data_end;
  logic [DATA_W-1:0] ram_rd_data;
  logic [15:0]       hit_cnt, miss_cnt;

  int n_vec = 0;
  int n_err = 0;

  ram_line_cache_reader dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .flush(flush),
    .ram_address(ram_address), .ram_cmd(ram_cmd), .ram_en(ram_en), .ram_rdy(ram_rdy),
    .ram_rd_valid(ram_rd_valid), .ram_rd_data_end(ram_rd_data_end), .ram_rd_data(ram_rd_data),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory image served on the read channel; line 0x10 carries the documented pattern.
  function automatic logic [DATA_W-1:0] mem_beat(input logic [ADDR_W-1:0] la, input int k);
    logic [31:0] x;
    logic [7:0]  kk;
    if (la == 27'h10) return (k == 0) ? 64'h1111_1111_1111_1111 : 64'h2222_2222_2222_2222;
    x  = 32'(la);
    kk = 8'(k);
    return {x[15:0], 8'hC0, kk, x[15:0] ^ 16'h5A5A, 16'h3C00 + x[15:0] + 16'(k)};
  endfunction

  function automatic logic [WORD_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] la;
    logic [127:0]      line;
    int                w;
    la   = a & ~27'h7;
    line = {mem_beat(la, 1), mem_beat(la, 0)};
    w    = int'(a % WPL);
    return line[w*WORD_W +: WORD_W];
  endfunction

  // Reference cache: which line address each index holds, plus request statistics.
  logic [ADDR_W-1:0] m_line [LINES];
  bit                m_val  [LINES];
  int                m_hits, m_misses;

  task automatic model_reset();
    for (int i = 0; i < LINES; i++) m_val[i] = 0;
    m_hits   = 0;
    m_misses = 0;
  endtask

  task automatic model_access(input logic [ADDR_W-1:0] a, input bit fl_req, input bit fl_mid,
                              output bit hit, output logic [WORD_W-1:0] word);
    logic [ADDR_W-1:0] la;
    int idx;
    la  = a & ~27'h7;
    idx = int'((a / WPL) % LINES);
    if (fl_req) for (int i = 0; i < LINES; i++) m_val[i] = 0;
    hit = m_val[idx] && (m_line[idx] == la);
    if (hit) m_hits++;
    else begin
      m_misses++;
      m_val[idx]  = 1;
      m_line[idx] = la;
      if (fl_mid) for (int i = 0; i < LINES; i++) m_val[i] = 0;
    end
    word = mem_word(a);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ram_en"}, ram_en, 0);
    check({tag, "_ram_cmd"}, ram_cmd, 0);
    check({tag, "_ram_addr"}, ram_address, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_data"}, rsp_data, 0);
    check({tag, "_hit_cnt"}, hit_cnt, 0);
    check({tag, "_miss_cnt"}, miss_cnt, 0);
    check({tag, "_req_ready"}, req_ready, 1);
  endtask

  // One request end to end; the path taken follows the DUT so a wrong hit/miss never stalls the run.
  task automatic txn(input logic [ADDR_W-1:0] a, input int stall, input bit fl_req,
                     input bit fl_mid, input bit exp_hit, input logic [WORD_W-1:0] exp_word);
    logic [ADDR_W-1:0] la;
    la = a & ~27'h7;
    req_valid = 1'b1;
    req_addr  = a;
    flush     = fl_req;
    check("req_ready_idle", req_ready, 1);
    step();
    req_valid = 1'b0;
    flush     = 1'b0;
    check("hit_pulse", rsp_valid, exp_hit);
    if (!ram_en) begin
      check("hit_data", rsp_data, exp_word);
      step();
      check("hit_pulse_end", rsp_valid, 0);
    end else begin
      check("miss_expected", exp_hit, 0);
      check("miss_cmd", ram_cmd, 3'b001);
      check("miss_addr", ram_address, la);
      check("busy_ready", req_ready, 0);
      for (int i = 0; i < stall; i++) begin
        step();
        check("stall_en", ram_en, 1);
        check("stall_addr", ram_address, la);
        check("stall_cmd", ram_cmd, 3'b001);
      end
      ram_rdy = 1'b1;
      step();
      ram_rdy = 1'b0;
      check("en_drop", ram_en, 0);
      for (int k = 0; k < BEATS; k++) begin
        flush           = fl_mid && (k == 0);
        ram_rd_valid    = 1'b1;
        ram_rd_data     = mem_beat(la, k);
        ram_rd_data_end = (k == BEATS - 1);
        step();
        flush = 1'b0;
      end
      ram_rd_valid    = 1'b0;
      ram_rd_data_end = 1'b0;
      check("fill_rsp_valid", rsp_valid, 1);
      check("fill_rsp_data", rsp_data, exp_word);
      step();
      check("fill_rsp_end", rsp_valid, 0);
      check("fill_rsp_hold", rsp_data, exp_word);
      check("ready_back", req_ready, 1);
    end
  endtask

  task automatic idle_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int i = 0; i < LINES; i++) m_val[i] = 0;
  endtask

  typedef struct {
    logic [ADDR_W-1:0] addr;
    int                stall;
    bit                fl_req;
    bit                fl_mid;
    bit                exp_hit;
    logic [WORD_W-1:0] exp_word;
  } vec_t;

  function automatic vec_t mk(input logic [ADDR_W-1:0] a, input int st, input bit fr,
                              input bit fm, input bit h, input logic [WORD_W-1:0] w);
    vec_t v;
    v.addr = a; v.stall = st; v.fl_req = fr; v.fl_mid = fm; v.exp_hit = h; v.exp_word = w;
    return v;
  endfunction

  vec_t vt [12];

  initial begin
    bit                mh;
    logic [WORD_W-1:0] mw;
    logic [ADDR_W-1:0] ra;

    vt[0]  = mk(27'h13, 0, 0, 0, 0, 16'h1111);
    vt[1]  = mk(27'h15, 0, 0, 0, 1, 16'h2222);
    vt[2]  = mk(27'h50, 5, 0, 0, 0, mem_word(27'h50));
    vt[3]  = mk(27'h13, 1, 0, 0, 0, 16'h1111);
    vt[4]  = mk(27'h17, 0, 0, 0, 1, 16'h2222);
    vt[5]  = mk(27'h50, 0, 0, 1, 0, mem_word(27'h50));
    vt[6]  = mk(27'h50, 2, 0, 0, 0, mem_word(27'h50));
    vt[7]  = mk(27'h08, 0, 0, 0, 0, mem_word(27'h08));
    vt[8]  = mk(27'h0F, 0, 0, 0, 1, mem_word(27'h0F));
    vt[9]  = mk(27'h09, 0, 1, 0, 0, mem_word(27'h09));
    vt[10] = mk(27'h21, 3, 0, 0, 0, mem_word(27'h21));
    vt[11] = mk(27'h22, 0, 0, 0, 1, mem_word(27'h22));

    reset_n = 1'b0; req_valid = 1'b0; req_addr = '0; flush = 1'b0;
    ram_rdy = 1'b0; ram_rd_valid = 1'b0; ram_rd_data_end = 1'b0; ram_rd_data = '0;
    model_reset();
    step();
    step();
    check_reset_outputs("reset");
    reset_n = 1'b1;
    step();

    for (int i = 0; i < 12; i++) begin
      model_access(vt[i].addr, vt[i].fl_req, vt[i].fl_mid, mh, mw);
      txn(vt[i].addr, vt[i].stall, vt[i].fl_req, vt[i].fl_mid, vt[i].exp_hit, vt[i].exp_word);
    end
    check("table_hit_cnt", hit_cnt, 4);
    check("table_miss_cnt", miss_cnt, 8);

    // Reset in the middle of a fill, followed by stale beats on the read channel.
    req_valid = 1'b1; req_addr = 27'h30;
    step();
    req_valid = 1'b0; ram_rdy = 1'b1;
    step();
    ram_rdy = 1'b0; ram_rd_valid = 1'b1; ram_rd_data = mem_beat(27'h30, 0);
    step();
    ram_rd_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midfill_reset");
    step();
    reset_n = 1'b1;
    ram_rd_valid = 1'b1; ram_rd_data_end = 1'b1; ram_rd_data = mem_beat(27'h30, 1);
    step();
    step();
    ram_rd_valid = 1'b0; ram_rd_data_end = 1'b0;
    check_reset_outputs("late_beats");
    model_reset();
    model_access(27'h13, 0, 0, mh, mw);
    txn(27'h13, 0, 0, 0, mh, mw);
    check("post_reset_miss_cnt", miss_cnt, 1);

    for (int i = 0; i < 200; i++) begin
      bit fr, fm;
      int st;
      ra = ADDR_W'($urandom_range(0, 127));
      st = $urandom_range(0, 3);
      fr = ($urandom_range(0, 7) == 0);
      fm = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) idle_flush();
      model_access(ra, fr, fm, mh, mw);
      txn(ra, st, fr, fm, mh, mw);
    end
    check("rand_hit_cnt", hit_cnt, 16'(m_hits));
    check("rand_miss_cnt", miss_cnt, 16'(m_misses));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
